// File: rtl/ucsbece154b_icache.sv
// Direct-mapped, read-only instruction cache with a four-state line-fill FSM.
// A hit returns the word combinationally in the same cycle. A miss latches the
// request, issues a line-aligned burst read, and captures words as the memory
// presents them. Ready_o stays low until the UPDATE cycle returns the word.
module ucsbece154b_icache #(
    parameter int NUM_SETS       = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ReadEnable_i,
    input  logic [ADDR_WIDTH-1:0] ReadAddress_i,
    output logic [31:0]           Instruction_o,
    output logic                  Ready_o,
    output logic                  MemReadRequest_o,
    output logic [ADDR_WIDTH-1:0] MemReadAddress_o,
    input  logic                  MemDataReady_i,
    input  logic [31:0]           MemDataIn_i
);

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
    localparam int INDEX_W  = $clog2(NUM_SETS);
    localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W - 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        FILL   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Address fields of the incoming fetch; the byte-offset bits are ignored.
    logic [OFFSET_W-1:0] addr_offset;
    logic [INDEX_W-1:0]  addr_index;
    logic [TAG_W-1:0]    addr_tag;
    wire                 unused_byte_bits = &{1'b0, ReadAddress_i[1:0]};

    assign addr_offset = ReadAddress_i[OFFSET_W+1:2];
    assign addr_index  = ReadAddress_i[INDEX_W+OFFSET_W+1:OFFSET_W+2];
    assign addr_tag    = ReadAddress_i[ADDR_WIDTH-1:INDEX_W+OFFSET_W+2];

    // Storage: valid bits are reset; tags and data are not.
    logic [NUM_SETS-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [31:0]         data_q [NUM_SETS][WORDS_PER_LINE];

    // Miss context, held from the miss cycle until the line is installed.
    logic [OFFSET_W-1:0] lat_offset_q;
    logic [INDEX_W-1:0]  lat_index_q;
    logic [TAG_W-1:0]    lat_tag_q;
    logic [OFFSET_W-1:0] count_q, count_d;

    logic                  hit;
    logic                  latch_en;
    logic                  mem_we;
    logic                  set_valid;
    logic                  ready;
    logic                  req;
    logic [31:0]           instr;
    logic [ADDR_WIDTH-1:0] line_addr;

    assign hit       = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
    assign line_addr = {lat_tag_q, lat_index_q, {(OFFSET_W+2){1'b0}}};

    // Next-state and output decode; every signal gets its default first.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        latch_en  = 1'b0;
        mem_we    = 1'b0;
        set_valid = 1'b0;
        ready     = 1'b1;
        req       = 1'b0;
        instr     = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (ReadEnable_i) begin
                    if (hit) begin
                        instr = data_q[addr_index][addr_offset];
                    end else begin
                        ready    = 1'b0;
                        latch_en = 1'b1;
                        count_d  = '0;
                        state_d  = REQ;
                    end
                end
            end
            REQ: begin
                ready = 1'b0;
                req   = 1'b1;
                if (MemDataReady_i) begin
                    mem_we  = 1'b1;
                    count_d = count_q + OFFSET_W'(1);
                    state_d = FILL;
                end
            end
            FILL: begin
                ready = 1'b0;
                req   = 1'b1;
                if (MemDataReady_i) begin
                    mem_we = 1'b1;
                    if (&count_q) begin
                        count_d = '0;
                        state_d = UPDATE;
                    end else begin
                        count_d = count_q + OFFSET_W'(1);
                    end
                end
            end
            UPDATE: begin
                set_valid = 1'b1;
                instr     = data_q[lat_index_q][lat_offset_q];
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Ready_o          = ready;
    assign Instruction_o    = instr;
    assign MemReadRequest_o = req;
    assign MemReadAddress_o = req ? line_addr : '0;

    // State register; reset abandons any fill in progress.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Burst word counter and latched miss context.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= '0;
            lat_offset_q <= '0;
            lat_index_q  <= '0;
            lat_tag_q    <= '0;
        end else begin
            count_q <= count_d;
            if (latch_en) begin
                lat_offset_q <= addr_offset;
                lat_index_q  <= addr_index;
                lat_tag_q    <= addr_tag;
            end
        end
    end

    // Valid bits: cleared on reset, set only in the UPDATE cycle.
    always_ff @(posedge clk) begin
        if (reset)          valid_q <= '0;
        else if (set_valid) valid_q[lat_index_q] <= 1'b1;
    end

    // Data and tag arrays: burst words land at the counter, tag on install.
    always_ff @(posedge clk) begin
        if (mem_we && !reset)    data_q[lat_index_q][count_q] <= MemDataIn_i;
        if (set_valid && !reset) tag_q[lat_index_q] <= lat_tag_q;
    end

endmodule

// File: tb/tb_ucsbece154b_icache.sv
// Directed bench for the instruction cache: cold miss, hits, gapped burst,
// conflict eviction, address change during fill and reset mid-fill.
module tb_ucsbece154b_icache;

    logic        clk;
    logic        reset;
    logic        re;
    logic [31:0] ra;
    logic [31:0] instr;
    logic        ready;
    logic        mreq;
    logic [31:0] maddr;
    logic        mdr;
    logic [31:0] md;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    ucsbece154b_icache dut (
        .clk              (clk),
        .reset            (reset),
        .ReadEnable_i     (re),
        .ReadAddress_i    (ra),
        .Instruction_o    (instr),
        .Ready_o          (ready),
        .MemReadRequest_o (mreq),
        .MemReadAddress_o (maddr),
        .MemDataReady_i   (mdr),
        .MemDataIn_i      (md)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch that should hit: result is checked in the same cycle.
    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        re = 1'b1; ra = addr; mdr = 1'b0;
        @(negedge clk);
        check("hit_ready", {31'b0, ready}, 32'd1);
        check("hit_memreq", {31'b0, mreq}, 32'd0);
        e = exp_q.pop_front();
        check("hit_instr", instr, e);
    endtask

    // Fetch that should miss; memory model returns w0..w3 with g0..g3 idle
    // cycles before each word. chg moves ReadAddress_i away during FILL.
    task automatic fetch_miss(input logic [31:0] addr,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3,
                              input int g0, input int g1, input int g2, input int g3,
                              input bit chg);
        logic [31:0] w[4];
        int          g[4];
        int          low_cnt;
        logic [31:0] e;
        logic [1:0]  off;
        w = '{w0, w1, w2, w3};
        g = '{g0, g1, g2, g3};
        off = addr[3:2];
        low_cnt = 0;
        exp_q.push_back(w[off]);
        @(posedge clk); #1;
        re = 1'b1; ra = addr; mdr = 1'b0;
        @(negedge clk);
        check("miss_ready", {31'b0, ready}, 32'd0);
        if (!ready) low_cnt++;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < g[i]; j++) begin
                @(posedge clk); #1;
                mdr = 1'b0;
                if (chg && i > 0) ra = 32'h0000_0020;
                @(negedge clk);
                check("gap_memreq", {31'b0, mreq}, 32'd1);
                check("gap_memaddr", maddr, {addr[31:4], 4'h0});
                check("gap_ready", {31'b0, ready}, 32'd0);
                if (!ready) low_cnt++;
            end
            @(posedge clk); #1;
            mdr = 1'b1; md = w[i];
            if (chg && i > 0) ra = 32'h0000_0020;
            @(negedge clk);
            check("fill_memreq", {31'b0, mreq}, 32'd1);
            check("fill_memaddr", maddr, {addr[31:4], 4'h0});
            check("fill_ready", {31'b0, ready}, 32'd0);
            if (!ready) low_cnt++;
        end
        // UPDATE cycle; a stray memory word here must not be written.
        @(posedge clk); #1;
        mdr = 1'b1; md = 32'hDEAD_BEEF;
        @(negedge clk);
        check("upd_ready", {31'b0, ready}, 32'd1);
        check("upd_memreq", {31'b0, mreq}, 32'd0);
        e = exp_q.pop_front();
        check("upd_instr", instr, e);
        check("penalty", low_cnt, 1 + g0 + g1 + g2 + g3 + 4);
        @(posedge clk); #1;
        mdr = 1'b0; re = 1'b0;
    endtask

    initial begin
        reset = 1'b1; re = 1'b0; ra = '0; mdr = 1'b0; md = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_memreq", {31'b0, mreq}, 32'd0);
        check("rst_memaddr", maddr, 32'h0);
        check("rst_instr", instr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'b0, ready}, 32'd1);

        // Cold miss, back-to-back burst, then hits within the line.
        fetch_miss(32'h10, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0, 1'b0);
        fetch_hit(32'h18, 32'hA2);
        fetch_hit(32'h14, 32'hA1);
        fetch_hit(32'h1C, 32'hA3);

        // Gapped burst: ready pattern 1,0,0,1,1,0,1.
        fetch_miss(32'h40, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 0, 2, 0, 1, 1'b0);
        fetch_hit(32'h4C, 32'hB3);
        fetch_hit(32'h44, 32'hB1);

        // Conflict on index 1: evict, then the original line misses again.
        fetch_miss(32'h90, 32'hC0, 32'hC1, 32'hC2, 32'hC3,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 0, 1'b0);
        fetch_hit(32'h94, 32'hC1);
        fetch_miss(32'h10, 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                   $urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom_range(0, 3), 1'b0);
        fetch_hit(32'h1C, 32'hA3);
        fetch_hit(32'h48, 32'hB2);

        // Address change during FILL; original word returned at UPDATE.
        fetch_miss(32'h28, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 1, 1, 0, 2, 1'b1);
        fetch_hit(32'h20, 32'hD0);

        // Reset after two words of a fill.
        @(posedge clk); #1;
        re = 1'b1; ra = 32'h100; mdr = 1'b0;
        @(negedge clk);
        check("mf_miss_ready", {31'b0, ready}, 32'd0);
        @(posedge clk); #1;
        mdr = 1'b1; md = 32'hE0;
        @(posedge clk); #1;
        md = 32'hE1;
        @(posedge clk); #1;
        mdr = 1'b0; reset = 1'b1; re = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; mdr = 1'b1; md = 32'h5555_5555;
        @(negedge clk);
        check("mf_memreq", {31'b0, mreq}, 32'd0);
        check("mf_memaddr", maddr, 32'h0);
        check("mf_ready", {31'b0, ready}, 32'd1);
        check("mf_instr", instr, 32'h0);
        @(posedge clk); #1;
        md = 32'h6666_6666;
        @(posedge clk); #1;
        mdr = 1'b0;
        fetch_miss(32'h100, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 0, 1, 0, 0, 1'b0);
        fetch_hit(32'h108, 32'hE2);
        // All valid bits were cleared, so a previously resident line misses.
        fetch_miss(32'h40, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 0, 0, 1, 0, 1'b0);
        fetch_hit(32'h40, 32'hF0);

        @(posedge clk); #1;
        re = 1'b0;
        @(negedge clk);
        check("end_idle_ready", {31'b0, ready}, 32'd1);
        check("end_idle_memreq", {31'b0, mreq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
